// File: rtl/sme_pkg.sv
// Shared types and constants for the hash-lookup stage that sits behind the hash accumulator.
// Optional statistics counters in the top are enabled with SME_LOOKUP_STATS_EN.
package sme_pkg;

    localparam int SME_NBITS  = 15;
    localparam int SME_RULE_W = 16;
    localparam int SME_TAG_W  = 8;

    typedef struct packed {
        logic                  hit;
        logic [SME_RULE_W-1:0] rule;
    } lookup_entry_t;

    typedef struct packed {
        lookup_entry_t         e;
        logic [SME_TAG_W-1:0]  tag;
    } lookup_res_t;

endpackage

// File: rtl/sme_lookup_fifo.sv
// First-word fall-through result buffer; head entry is visible combinationally while not empty.
// Pushes while full are ignored; the top's credit counter keeps that from ever happening.
module sme_lookup_fifo
    import sme_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(lookup_res_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_full;
    logic             w_empty;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push && !w_full)
                r_wp <= r_wp + 1'b1;
            if (i_pop && !w_empty)
                r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !w_full)
            r_mem[r_wp[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rp[AW-1:0]];
    assign o_valid = !w_empty;

endmodule

// File: rtl/sme_hash_lookup.sv
// Rule-table lookup addressed by the accumulator hash, with credit backpressure and an in-order result FIFO.
// Define SME_LOOKUP_STATS_EN to add saturating hit/miss counters with a synchronous clear.
module sme_hash_lookup
    import sme_pkg::*;
#(
    parameter int NBITS      = SME_NBITS,
    parameter int RULE_W     = SME_RULE_W,
    parameter int TAG_W      = SME_TAG_W,
    parameter int RAM_LAT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NBITS-1:0]  in_hash,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wr_en,
    input  logic [NBITS-1:0]  wr_addr,
    input  logic [RULE_W:0]   wr_data,
    output logic              out_hit,
    output logic [RULE_W-1:0] out_rule,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SME_LOOKUP_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = RULE_W + 1 + TAG_W;

    logic [RULE_W:0]    r_mem [2**NBITS];
    logic [RULE_W:0]    r_rd_data [RAM_LAT];
    logic [TAG_W-1:0]   r_tag [RAM_LAT];
    logic [RAM_LAT-1:0] r_vld;
    logic               r_up;
    logic [CW-1:0]      r_credit;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [RULE_W:0]    w_last;
    logic [RULE_W-1:0]  w_rule;
    logic [RW-1:0]      w_fifo_out;
    logic               w_fifo_valid;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign in_ready   = r_up && (r_credit < CW'(FIFO_DEPTH));

    // Stage 0 reads the table before this cycle's write lands, giving read-first collisions.
    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[wr_addr] <= wr_data;
        r_rd_data[0] <= r_mem[in_hash];
        r_tag[0]     <= in_tag;
        for (int i = 1; i < RAM_LAT; i++) begin
            r_rd_data[i] <= r_rd_data[i-1];
            r_tag[i]     <= r_tag[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_up     <= 1'b0;
            r_credit <= '0;
        end else begin
            r_vld[0] <= w_in_xfer;
            for (int i = 1; i < RAM_LAT; i++)
                r_vld[i] <= r_vld[i-1];
            r_up <= 1'b1;
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign w_last = r_rd_data[RAM_LAT-1];
    assign w_rule = w_last[RULE_W] ? w_last[RULE_W-1:0] : '0;

    sme_lookup_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld[RAM_LAT-1]),
        .i_data  ({w_last[RULE_W], w_rule, r_tag[RAM_LAT-1]}),
        .i_pop   (w_out_xfer),
        .o_data  (w_fifo_out),
        .o_valid (w_fifo_valid)
    );

    // Gate with valid so the outputs read zero while the buffer is empty.
    assign out_valid = w_fifo_valid;
    assign out_hit   = w_fifo_valid && w_fifo_out[RULE_W+TAG_W];
    assign out_rule  = w_fifo_valid ? w_fifo_out[TAG_W +: RULE_W] : '0;
    assign out_tag   = w_fifo_valid ? w_fifo_out[TAG_W-1:0] : '0;

`ifdef SME_LOOKUP_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (stat_clr) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (w_out_xfer) begin
            if (out_hit) begin
                if (r_stat_hits != '1)
                    r_stat_hits <= r_stat_hits + 32'd1;
            end else if (r_stat_misses != '1) begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule
